// File: rtl/router_pkg.sv
// Shared types and constants for the router input-side packet sequencer.
package router_pkg;
    localparam int          ROUTER_NUM_PORTS    = 3;
    localparam logic [1:0]  ROUTER_INVALID_ADDR = 2'b11;

    typedef enum logic [2:0] {
        DECODE_ADDRESS,
        LOAD_FIRST_DATA,
        LOAD_DATA,
        FIFO_FULL_STATE,
        LOAD_AFTER_FULL,
        LOAD_PARITY,
        CHECK_PARITY_ERROR,
        WAIT_TILL_EMPTY
    } router_state_t;
endpackage

// File: rtl/router_fsm_if.sv
// Source/synchroniser/register-side signals of the router FSM.
// The master side drives the FSM inputs; the slave side is the FSM itself.
interface router_fsm_if;
    logic       pkt_valid;
    logic [1:0] data_in;
    logic       fifo_full;
    logic       fifo_empty_0, fifo_empty_1, fifo_empty_2;
    logic       soft_reset_0, soft_reset_1, soft_reset_2;
    logic       parity_done;
    logic       low_pkt_valid;
    logic       detect_add;
    logic       lfd_state;
    logic       ld_state;
    logic       laf_state;
    logic       full_state;
    logic       write_enb_reg;
    logic       rst_int_reg;
    logic       busy;

    modport master (
        output pkt_valid, data_in, fifo_full,
               fifo_empty_0, fifo_empty_1, fifo_empty_2,
               soft_reset_0, soft_reset_1, soft_reset_2,
               parity_done, low_pkt_valid,
        input  detect_add, lfd_state, ld_state, laf_state, full_state,
               write_enb_reg, rst_int_reg, busy
    );

    modport slave (
        input  pkt_valid, data_in, fifo_full,
               fifo_empty_0, fifo_empty_1, fifo_empty_2,
               soft_reset_0, soft_reset_1, soft_reset_2,
               parity_done, low_pkt_valid,
        output detect_add, lfd_state, ld_state, laf_state, full_state,
               write_enb_reg, rst_int_reg, busy
    );
endinterface

// File: rtl/router_fsm.sv
// Packet sequencer for the 1x3 router input side: header decode, payload load,
// full-stall handling, parity load/check, and per-port soft-reset abort.
module router_fsm
    import router_pkg::*;
#(
    parameter int NUM_PORTS = ROUTER_NUM_PORTS,
    parameter int ADDR_W    = 2
) (
    input  logic          clock,
    input  logic          resetn,
    router_fsm_if.slave   bus
);

    router_state_t       state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [NUM_PORTS-1:0] empty_vec, srst_vec;
    logic                empty_live, empty_held, srst_held;

    // Out-of-range addresses select nothing, so 2'b11 never looks empty or reset.
    function automatic logic port_sel(input logic [NUM_PORTS-1:0] v,
                                      input logic [ADDR_W-1:0]    a);
        logic r;
        r = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++)
            if (a == ADDR_W'(i)) r = v[i];
        return r;
    endfunction

    assign empty_vec  = {bus.fifo_empty_2, bus.fifo_empty_1, bus.fifo_empty_0};
    assign srst_vec   = {bus.soft_reset_2, bus.soft_reset_1, bus.soft_reset_0};
    assign empty_live = port_sel(empty_vec, bus.data_in);
    assign empty_held = port_sel(empty_vec, addr_q);
    assign srst_held  = port_sel(srst_vec, addr_q);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= DECODE_ADDRESS;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        unique case (state_q)
            DECODE_ADDRESS: begin
                if (bus.pkt_valid) addr_d = bus.data_in;
                if (bus.pkt_valid && bus.data_in != ROUTER_INVALID_ADDR)
                    state_d = empty_live ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
            end
            WAIT_TILL_EMPTY:    if (empty_held) state_d = LOAD_FIRST_DATA;
            LOAD_FIRST_DATA:    state_d = LOAD_DATA;
            LOAD_DATA: begin
                if (bus.fifo_full)       state_d = FIFO_FULL_STATE;
                else if (!bus.pkt_valid) state_d = LOAD_PARITY;
            end
            FIFO_FULL_STATE:    if (!bus.fifo_full) state_d = LOAD_AFTER_FULL;
            LOAD_AFTER_FULL: begin
                if (bus.parity_done)        state_d = DECODE_ADDRESS;
                else if (bus.low_pkt_valid) state_d = LOAD_PARITY;
                else                        state_d = LOAD_DATA;
            end
            LOAD_PARITY:        state_d = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR: state_d = bus.fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
            default:            state_d = DECODE_ADDRESS;
        endcase
        // A timeout on the addressed output abandons the packet from any active state.
        if (state_q != DECODE_ADDRESS && srst_held) state_d = DECODE_ADDRESS;
    end

    assign bus.detect_add    = (state_q == DECODE_ADDRESS);
    assign bus.lfd_state     = (state_q == LOAD_FIRST_DATA);
    assign bus.ld_state      = (state_q == LOAD_DATA);
    assign bus.laf_state     = (state_q == LOAD_AFTER_FULL);
    assign bus.full_state    = (state_q == FIFO_FULL_STATE);
    assign bus.write_enb_reg = (state_q == LOAD_DATA) || (state_q == LOAD_PARITY)
                            || (state_q == LOAD_AFTER_FULL);
    assign bus.rst_int_reg   = (state_q == CHECK_PARITY_ERROR);
    assign bus.busy          = (state_q != DECODE_ADDRESS) && (state_q != LOAD_DATA);

endmodule

// File: tb/tb_router_fsm.sv
// Directed bench for router_fsm: each step checks the full Moore output vector
// against a hand-written constant for the expected state.
module tb_router_fsm;
    logic clock  = 1'b0;
    logic resetn = 1'b0;
    int   checks = 0;
    int   errors = 0;

    router_fsm_if bus ();
    router_fsm dut (.clock(clock), .resetn(resetn), .bus(bus.slave));

    always #5 clock = ~clock;

    // {detect_add, lfd, ld, laf, full, write_enb, rst_int, busy}
    localparam logic [7:0] O_DA  = 8'b1000_0000;
    localparam logic [7:0] O_LFD = 8'b0100_0001;
    localparam logic [7:0] O_LD  = 8'b0010_0100;
    localparam logic [7:0] O_LAF = 8'b0001_0101;
    localparam logic [7:0] O_FFS = 8'b0000_1001;
    localparam logic [7:0] O_LP  = 8'b0000_0101;
    localparam logic [7:0] O_CHK = 8'b0000_0011;
    localparam logic [7:0] O_WTE = 8'b0000_0001;

    logic [7:0] obs;
    assign obs = {bus.detect_add, bus.lfd_state, bus.ld_state, bus.laf_state,
                  bus.full_state, bus.write_enb_reg, bus.rst_int_reg, bus.busy};

    task automatic chk(input string tag, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        bus.pkt_valid     = 1'b0;
        bus.data_in       = 2'b00;
        bus.fifo_full     = 1'b0;
        bus.fifo_empty_0  = 1'b1;
        bus.fifo_empty_1  = 1'b1;
        bus.fifo_empty_2  = 1'b1;
        bus.soft_reset_0  = 1'b0;
        bus.soft_reset_1  = 1'b0;
        bus.soft_reset_2  = 1'b0;
        bus.parity_done   = 1'b0;
        bus.low_pkt_valid = 1'b0;

        #3 chk("reset_state", O_DA);
        step(); resetn = 1'b1;
        step(); chk("idle_after_reset", O_DA);

        // Minimal-stall packet to port 1 with three payload cycles.
        bus.pkt_valid = 1'b1; bus.data_in = 2'b01;
        step(); chk("p1_lfd", O_LFD);
        bus.data_in = 2'b00;
        step(); chk("p1_ld0", O_LD);
        step(); chk("p1_ld1", O_LD);
        step(); chk("p1_ld2", O_LD);
        bus.pkt_valid = 1'b0;
        step(); chk("p1_lp", O_LP);
        step(); chk("p1_chk", O_CHK);
        step(); chk("p1_done", O_DA);

        // Port 2 occupied: wait four cycles, then load.
        bus.pkt_valid = 1'b1; bus.data_in = 2'b10; bus.fifo_empty_2 = 1'b0;
        step(); chk("p2_wte0", O_WTE);
        bus.pkt_valid = 1'b0; bus.data_in = 2'b00;
        step(); chk("p2_wte1", O_WTE);
        step(); chk("p2_wte2", O_WTE);
        step(); chk("p2_wte3", O_WTE);
        bus.fifo_empty_2 = 1'b1;
        step(); chk("p2_lfd", O_LFD);
        bus.pkt_valid = 1'b1;
        step(); chk("p2_ld", O_LD);

        // Full stall for three cycles, then low_pkt_valid path to parity.
        bus.fifo_full = 1'b1;
        step(); chk("ffs0", O_FFS);
        step(); chk("ffs1", O_FFS);
        step(); chk("ffs2", O_FFS);
        bus.fifo_full = 1'b0; bus.low_pkt_valid = 1'b1; bus.pkt_valid = 1'b0;
        step(); chk("laf", O_LAF);
        step(); chk("laf_to_lp", O_LP);
        bus.low_pkt_valid = 1'b0;
        step(); chk("laf_chk", O_CHK);
        step(); chk("laf_done", O_DA);

        // Invalid address is ignored.
        bus.pkt_valid = 1'b1; bus.data_in = 2'b11;
        step(); chk("addr3_a", O_DA);
        step(); chk("addr3_b", O_DA);
        bus.pkt_valid = 1'b0;

        // Async reset mid-LOAD_DATA takes effect before the next edge.
        bus.pkt_valid = 1'b1; bus.data_in = 2'b00;
        step(); chk("rst_lfd", O_LFD);
        step(); chk("rst_ld", O_LD);
        #2 resetn = 1'b0;
        #1 chk("rst_async", O_DA);
        bus.pkt_valid = 1'b0;
        step(); resetn = 1'b1;
        step(); chk("rst_release", O_DA);

        // Soft reset: non-addressed port ignored, addressed port aborts.
        bus.pkt_valid = 1'b1; bus.data_in = 2'b00;
        step(); chk("sr_lfd", O_LFD);
        step(); chk("sr_ld", O_LD);
        bus.fifo_full = 1'b1;
        step(); chk("sr_ffs", O_FFS);
        bus.soft_reset_1 = 1'b1;
        step(); chk("sr1_ignored", O_FFS);
        bus.soft_reset_1 = 1'b0; bus.soft_reset_0 = 1'b1;
        step(); chk("sr0_abort", O_DA);
        bus.soft_reset_0 = 1'b0; bus.fifo_full = 1'b0; bus.pkt_valid = 1'b0;
        step(); chk("sr_idle", O_DA);

        // CHECK_PARITY_ERROR with full -> stall; LAF with parity_done -> decode.
        bus.pkt_valid = 1'b1; bus.data_in = 2'b01;
        step(); chk("cp_lfd", O_LFD);
        step(); chk("cp_ld", O_LD);
        bus.pkt_valid = 1'b0;
        step(); chk("cp_lp", O_LP);
        bus.fifo_full = 1'b1;
        step(); chk("cp_chk", O_CHK);
        step(); chk("cp_ffs", O_FFS);
        bus.fifo_full = 1'b0; bus.parity_done = 1'b1;
        step(); chk("cp_laf", O_LAF);
        step(); chk("cp_pdone", O_DA);
        bus.parity_done = 1'b0;

        // Full beats !pkt_valid in LOAD_DATA; LAF else-branch returns to LD;
        // soft reset on port 2 aborts from LOAD_DATA.
        bus.pkt_valid = 1'b1; bus.data_in = 2'b10;
        step(); chk("pr_lfd", O_LFD);
        step(); chk("pr_ld", O_LD);
        bus.pkt_valid = 1'b0; bus.fifo_full = 1'b1;
        step(); chk("pr_full_wins", O_FFS);
        bus.fifo_full = 1'b0;
        step(); chk("pr_laf", O_LAF);
        step(); chk("pr_laf_to_ld", O_LD);
        bus.pkt_valid = 1'b1; bus.soft_reset_2 = 1'b1;
        step(); chk("sr2_abort", O_DA);
        bus.soft_reset_2 = 1'b0; bus.pkt_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
